base_decode_pipe: RTL
=====================

# base_decode_pipe

Registered binary-to-one-hot decoder with a valid/ready handshake on both sides, the decode-side counterpart of base_encode. It takes an encoded index (tag, way or port number) from a producer and delivers the matching one-hot select vector to a consumer. It has one cycle of latency and full throughput. A two-entry skid buffer keeps the input ready signal independent of the output ready signal, with no combinational path between them. Out-of-range indices are flagged on a sideband error bit and never decoded.

## Interface
- enc_width, default 1: width of the encoded index; must be ≥ 1.
- dec_width, default 2: width of the one-hot output; must satisfy 2 ≤ dec_width ≤ 2^enc_width.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  1  input index valid.
- i_r  output  1  input ready; the block accepts an index when i_v & i_r at a rising edge.
- i_d  input  [0:enc_width-1]  encoded index, unsigned, i_d[0] is the MSB.
- o_v  output  1  output valid.
- o_r  input  1  output ready; the consumer takes an output when o_v & o_r at a rising edge.
- o_d  output  [0:dec_width-1]  one-hot decode; index k sets o_d[k] (bit 0 is leftmost).
- o_err  output  1  asserted with o_v when the held index is ≥ dec_width; o_d is all zeros in that case.

## Operation
- Storage is two entries: an output stage (drives o_v, o_d, o_err) and a skid stage. Each entry holds a valid bit, the decoded vector and the error bit.
- Decoding happens before storage. The stored entry is o_d = one-hot(i_d) and o_err = 0 when i_d < dec_width; otherwise o_d = 0 and o_err = 1.
- i_r = !reset & !skid_valid. i_r depends only on the reset pin and registered state, never on o_r or i_v.
- An accept (i_v & i_r) routes the entry as follows:
  - Into the output stage if the output stage is empty, or if it holds an entry that is consumed this cycle (o_v & o_r).
  - Otherwise into the skid stage.
- If the skid stage is full and o_r is asserted, the skid entry moves to the output stage and the skid stage empties. No accept is possible that cycle because i_r = 0.
- Ordering is strict FIFO. Entries are never dropped or duplicated.
- While o_v & !o_r, the values of o_d and o_err must not change.
- When o_v = 0, o_d and o_err are 0. The output stage clears its data when it drains without a refill.
- Reset, asserted at any time including mid-transfer, asynchronously clears both valid bits, the data and the error bits. All in-flight entries are discarded.
- o_err is informational only: an erroneous entry flows through the handshake like any other entry.

## Timing
- Reset values: o_v = 0, o_d = 0, o_err = 0. i_r = 0 while reset is high and 1 from the first cycle after deassertion.
- Latency: an index accepted at edge N appears on o_v/o_d at edge N (visible in cycle N+1). There is no combinational path from i_d to o_d.
- Throughput: with o_r held high, one accept and one output per cycle, and the skid stage stays empty.
- Output stall with the output stage full: the next accept fills the skid stage, and i_r falls in the following cycle.
- Release: the first cycle with o_r = 1 moves the skid entry to the output stage, and i_r rises in the following cycle.
- Simultaneous accept and consume with the output stage full and the skid stage empty: the new entry replaces the output stage directly.

## Test plan
All scenarios use enc_width = 2, dec_width = 3.
- Reset: hold reset with i_v = 1 → o_v = 0, o_d = 000, o_err = 0, i_r = 0. Deassert reset → i_r = 1 next cycle, o_v stays 0 until the first accept.
- Streaming: o_r = 1; feed i_d = 0, 1, 2 on consecutive cycles → o_d = 100, 010, 001 on the following consecutive cycles, o_err = 0 throughout, i_r stays 1.
- Out of range: i_d = 3 → o_v = 1, o_d = 000, o_err = 1. Next input i_d = 1 → o_d = 010, o_err = 0.
- Backpressure:
  - o_r = 0; feed i_d = 0 then 2 → output stage shows 100 held stable, skid holds 001, and i_r = 0 from the next cycle.
  - Keep i_v = 1 with i_d = 1 presented (not accepted while i_r = 0).
  - Raise o_r → outputs appear in the order 100, 001, 010, with no loss and no duplicate.
- Reset mid-operation: with both stages full and o_r = 0, pulse reset asynchronously between clock edges → o_v drops immediately, o_d = 000, and no stale entry appears after reset.
- Sustained throughput: o_r = 1 with i_v = 1 for 8 cycles of random indices 0..2 → exactly 8 correct one-hot outputs on back-to-back cycles, and i_r never falls.

Source files
------------

// File: rtl/base_decode_pipe.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// A two-entry store (output stage + skid stage) makes i_r depend only on
// registered state and the reset pin, never on o_r or i_v.
module base_decode_pipe #(
  parameter int unsigned enc_width = 1,
  parameter int unsigned dec_width = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [0:enc_width-1] i_d,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:dec_width-1] o_d,
  output logic                 o_err
);

  // Output stage
  logic                 out_v_q,   out_v_d;
  logic [0:dec_width-1] out_d_q,   out_d_d;
  logic                 out_err_q, out_err_d;

  // Skid stage
  logic                 skid_v_q,   skid_v_d;
  logic [0:dec_width-1] skid_d_q,   skid_d_d;
  logic                 skid_err_q, skid_err_d;

  // Decoded form of the incoming index
  logic [0:dec_width-1] dec_d;
  logic                 dec_err;

  logic accept;
  logic out_free;

  // Decode before storage; out-of-range indices produce an all-zero vector.
  always_comb begin
    int unsigned idx;
    idx     = 32'(i_d);
    dec_d   = '0;
    dec_err = (idx >= dec_width);
    for (int unsigned k = 0; k < dec_width; k++) begin
      dec_d[k] = (idx == k);
    end
  end

  // Handshake terms; ready comes only from the skid flag and the reset pin.
  always_comb begin
    i_r      = !reset && !skid_v_q;
    accept   = i_v && i_r;
    // The output stage can take a new entry when empty or being consumed.
    out_free = !out_v_q || o_r;
  end

  // Next-state routing for both stages.
  always_comb begin
    out_v_d    = out_v_q;
    out_d_d    = out_d_q;
    out_err_d  = out_err_q;
    skid_v_d   = skid_v_q;
    skid_d_d   = skid_d_q;
    skid_err_d = skid_err_q;

    if (skid_v_q) begin
      // Skid full implies output full and i_r low; only a release can happen.
      if (o_r) begin
        out_v_d    = 1'b1;
        out_d_d    = skid_d_q;
        out_err_d  = skid_err_q;
        skid_v_d   = 1'b0;
        skid_d_d   = '0;
        skid_err_d = 1'b0;
      end
    end else if (accept) begin
      if (out_free) begin
        out_v_d   = 1'b1;
        out_d_d   = dec_d;
        out_err_d = dec_err;
      end else begin
        skid_v_d   = 1'b1;
        skid_d_d   = dec_d;
        skid_err_d = dec_err;
      end
    end else if (out_v_q && o_r) begin
      // Drain without refill: clear data so idle outputs read zero.
      out_v_d   = 1'b0;
      out_d_d   = '0;
      out_err_d = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v_q    <= 1'b0;
      out_d_q    <= '0;
      out_err_q  <= 1'b0;
      skid_v_q   <= 1'b0;
      skid_d_q   <= '0;
      skid_err_q <= 1'b0;
    end else begin
      out_v_q    <= out_v_d;
      out_d_q    <= out_d_d;
      out_err_q  <= out_err_d;
      skid_v_q   <= skid_v_d;
      skid_d_q   <= skid_d_d;
      skid_err_q <= skid_err_d;
    end
  end

  // Outputs come straight from the output stage registers.
  always_comb begin
    o_v   = out_v_q;
    o_d   = out_d_q;
    o_err = out_err_q;
  end

endmodule
